calc_cmd_parser: RTL and testbench

- Parametrised successor to the fixed 16-bit calculator front-end parser.
- Consumes the UART receive byte stream (rx_data/rx_valid) and parses ASCII command lines into signed-flag/operator/operand fields of width OPW.
- Buffers parsed commands in a DEPTH-entry queue; the ALU drains it through a valid/ready handshake.
- Adds malformed-line recovery, drop signalling and queue occupancy, none of which the previous parser has.

---
 rtl/calc_pkg.sv | 90 +++++++++
 rtl/calc_cmd_fifo.sv | 57 +++++
 rtl/calc_cmd_parser.sv | 215 +++++++++++++++++++++
 tb/tb_calc_cmd_parser.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command parser: op codes, ASCII
// constants, parser state encoding and character classification helpers.
package calc_pkg;

   localparam int unsigned OPC_W = 5;

   localparam logic [OPC_W-1:0] OP_ADD = 5'd0;
   localparam logic [OPC_W-1:0] OP_SUB = 5'd1;
   localparam logic [OPC_W-1:0] OP_MUL = 5'd2;
   localparam logic [OPC_W-1:0] OP_DIV = 5'd3;
   localparam logic [OPC_W-1:0] OP_MOD = 5'd4;
   localparam logic [OPC_W-1:0] OP_AND = 5'd5;
   localparam logic [OPC_W-1:0] OP_OR  = 5'd6;
   localparam logic [OPC_W-1:0] OP_XOR = 5'd7;
   localparam logic [OPC_W-1:0] OP_SHL = 5'd8;
   localparam logic [OPC_W-1:0] OP_SHR = 5'd9;

   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_SP    = 8'h20;
   localparam logic [7:0] CH_HASH  = 8'h23;
   localparam logic [7:0] CH_PCT   = 8'h25;
   localparam logic [7:0] CH_AMP   = 8'h26;
   localparam logic [7:0] CH_STAR  = 8'h2A;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_COMMA = 8'h2C;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_SLASH = 8'h2F;
   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_9     = 8'h39;
   localparam logic [7:0] CH_LT    = 8'h3C;
   localparam logic [7:0] CH_GT    = 8'h3E;
   localparam logic [7:0] CH_UA    = 8'h41;
   localparam logic [7:0] CH_UF    = 8'h46;
   localparam logic [7:0] CH_CARET = 8'h5E;
   localparam logic [7:0] CH_LA    = 8'h61;
   localparam logic [7:0] CH_LF_HEX = 8'h66;
   localparam logic [7:0] CH_S     = 8'h73;
   localparam logic [7:0] CH_PIPE  = 8'h7C;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OP,
      ST_SRC1,
      ST_SRC2,
      ST_DISCARD
   } state_e;

   typedef struct packed {
      logic             valid;
      logic [OPC_W-1:0] code;
   } op_dec_t;

   // Map an operator character to its op code; valid=0 for non-operators.
   function automatic op_dec_t op_decode(input logic [7:0] c);
      op_dec_t d;
      d.valid = 1'b1;
      d.code  = OP_ADD;
      case (c)
         CH_PLUS:  d.code = OP_ADD;
         CH_MINUS: d.code = OP_SUB;
         CH_STAR:  d.code = OP_MUL;
         CH_SLASH: d.code = OP_DIV;
         CH_PCT:   d.code = OP_MOD;
         CH_AMP:   d.code = OP_AND;
         CH_PIPE:  d.code = OP_OR;
         CH_CARET: d.code = OP_XOR;
         CH_LT:    d.code = OP_SHL;
         CH_GT:    d.code = OP_SHR;
         default:  d.valid = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic is_dec(input logic [7:0] c);
      return (c >= CH_0) && (c <= CH_9);
   endfunction

   function automatic logic is_hex(input logic [7:0] c);
      return is_dec(c) || ((c >= CH_UA) && (c <= CH_UF)) ||
             ((c >= CH_LA) && (c <= CH_LF_HEX));
   endfunction

   // Letters a-f/A-F share low nibbles 1..6, so +9 yields 10..15.
   function automatic logic [3:0] hex_val(input logic [7:0] c);
      if (is_dec(c)) return c[3:0];
      return 4'(c[3:0] + 4'd9);
   endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// First-word fall-through command queue; a pop frees a slot for a
// same-cycle push even when full.
module calc_cmd_fifo #(
   parameter int unsigned W     = 38,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [W-1:0]               data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/calc_cmd_parser.sv
// ASCII command-line parser feeding a command queue for the calculator ALU.
// Optional decimal operands ('#' prefix) are enabled by CALC_DEC_INPUT_EN.
module calc_cmd_parser
   import calc_pkg::*;
#(
   parameter int unsigned OPW   = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic                     cmd_signed,
   output logic [OPC_W-1:0]         cmd_op,
   output logic [OPW-1:0]           cmd_src1,
   output logic [OPW-1:0]           cmd_src2,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     parse_err,
   output logic                     cmd_drop
);

   localparam int unsigned HEX_MAX = OPW / 4;
   localparam int unsigned CNTW    = 5;
   localparam int unsigned PW      = 1 + OPC_W + 2 * OPW;
`ifdef CALC_DEC_INPUT_EN
   localparam int unsigned DW      = OPW + 4;
   localparam int unsigned DEC_MAX = 20;
`endif

   state_e            state_q;
   logic              sgn_q;
   logic [OPC_W-1:0]  op_q;
   logic [OPW-1:0]    acc1_q;
   logic [OPW-1:0]    acc2_q;
   logic [CNTW-1:0]   cnt_q;
   logic              err_q;
   logic              commit_q;
   logic [PW-1:0]     commit_data_q;
   logic              drop_q;
`ifdef CALC_DEC_INPUT_EN
   logic              dec_q;
   logic [DW-1:0]     dec_wide_c;
`endif

   op_dec_t           opd_c;
   logic              byte_c;
   logic              is_lf_c;
   logic              dig_ok_c;
   logic              hash_ok_c;
   logic              bad_c;
   logic [OPW-1:0]    acc_cur_c;
   logic [OPW-1:0]    acc_nxt_c;
   logic              pop_c;
   logic              full_c;
   logic              empty_c;
   logic [PW-1:0]     head_c;
   logic [PW-1:0]     shown_c;

   assign opd_c   = op_decode(rx_data);
   assign byte_c  = rx_valid && (rx_data != CH_CR);
   assign is_lf_c = (rx_data == CH_LF);

   // Digit acceptance and accumulator update for whichever operand is active.
   always_comb begin
      acc_cur_c = (state_q == ST_SRC2) ? acc2_q : acc1_q;
      acc_nxt_c = acc_cur_c;
      dig_ok_c  = 1'b0;
      hash_ok_c = 1'b0;
`ifdef CALC_DEC_INPUT_EN
      dec_wide_c = DW'(acc_cur_c) * DW'(10) + DW'(rx_data[3:0]);
      hash_ok_c  = (rx_data == CH_HASH) && (cnt_q == '0) && !dec_q;
      if (dec_q) begin
         if (is_dec(rx_data) && (cnt_q < CNTW'(DEC_MAX)) &&
             (dec_wide_c[DW-1:OPW] == '0)) begin
            dig_ok_c  = 1'b1;
            acc_nxt_c = dec_wide_c[OPW-1:0];
         end
      end else
`endif
      if (is_hex(rx_data) && (cnt_q < CNTW'(HEX_MAX))) begin
         dig_ok_c  = 1'b1;
         acc_nxt_c = {acc_cur_c[OPW-5:0], hex_val(rx_data)};
      end
   end

   // Classify the current byte as malformed for the current state.
   always_comb begin
      bad_c = 1'b0;
      if (byte_c) begin
         case (state_q)
            ST_IDLE: bad_c = !((rx_data == CH_SP) || is_lf_c ||
                               (rx_data == CH_S) || opd_c.valid);
            ST_OP:   bad_c = !opd_c.valid;
            ST_SRC1: bad_c = !(dig_ok_c || hash_ok_c ||
                               ((rx_data == CH_COMMA) && (cnt_q != '0)));
            ST_SRC2: bad_c = !(dig_ok_c || hash_ok_c ||
                               (is_lf_c && (cnt_q != '0)));
            default: bad_c = 1'b0;
         endcase
      end
   end

   // Line parser FSM; a commit is staged one edge before the queue write.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state_q       <= ST_IDLE;
         sgn_q         <= 1'b0;
         op_q          <= '0;
         acc1_q        <= '0;
         acc2_q        <= '0;
         cnt_q         <= '0;
         err_q         <= 1'b0;
         commit_q      <= 1'b0;
         commit_data_q <= '0;
         drop_q        <= 1'b0;
`ifdef CALC_DEC_INPUT_EN
         dec_q         <= 1'b0;
`endif
      end else begin
         err_q    <= 1'b0;
         commit_q <= 1'b0;
         drop_q   <= commit_q && full_c && !pop_c;
         if (state_q == ST_IDLE) begin
            acc1_q <= '0;
            acc2_q <= '0;
            cnt_q  <= '0;
`ifdef CALC_DEC_INPUT_EN
            dec_q  <= 1'b0;
`endif
         end
         if (byte_c) begin
            if (bad_c) begin
               err_q   <= 1'b1;
               state_q <= is_lf_c ? ST_IDLE : ST_DISCARD;
            end else begin
               case (state_q)
                  ST_IDLE: begin
                     if (rx_data == CH_S) begin
                        sgn_q   <= 1'b1;
                        state_q <= ST_OP;
                     end else if (opd_c.valid) begin
                        sgn_q   <= 1'b0;
                        op_q    <= opd_c.code;
                        state_q <= ST_SRC1;
                     end
                  end
                  ST_OP: begin
                     op_q    <= opd_c.code;
                     state_q <= ST_SRC1;
                  end
                  ST_SRC1: begin
                     if (dig_ok_c) begin
                        acc1_q <= acc_nxt_c;
                        cnt_q  <= cnt_q + CNTW'(1);
                     end
`ifdef CALC_DEC_INPUT_EN
                     else if (hash_ok_c) dec_q <= 1'b1;
`endif
                     else begin
                        cnt_q   <= '0;
                        state_q <= ST_SRC2;
`ifdef CALC_DEC_INPUT_EN
                        dec_q   <= 1'b0;
`endif
                     end
                  end
                  ST_SRC2: begin
                     if (dig_ok_c) begin
                        acc2_q <= acc_nxt_c;
                        cnt_q  <= cnt_q + CNTW'(1);
                     end
`ifdef CALC_DEC_INPUT_EN
                     else if (hash_ok_c) dec_q <= 1'b1;
`endif
                     else begin
                        commit_q      <= 1'b1;
                        commit_data_q <= {sgn_q, op_q, acc1_q, acc2_q};
                        state_q       <= ST_IDLE;
                     end
                  end
                  ST_DISCARD: begin
                     if (is_lf_c) state_q <= ST_IDLE;
                  end
                  default: state_q <= ST_IDLE;
               endcase
            end
         end
      end
   end

   calc_cmd_fifo #(
      .W     (PW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_i   (n_rst),
      .push_i  (commit_q),
      .data_i  (commit_data_q),
      .pop_i   (pop_c),
      .data_o  (head_c),
      .full_o  (full_c),
      .empty_o (empty_c),
      .count_o (fifo_count)
   );

   assign cmd_valid = !empty_c;
   assign pop_c     = cmd_valid && cmd_ready;
   assign shown_c   = cmd_valid ? head_c : '0;
   assign {cmd_signed, cmd_op, cmd_src1, cmd_src2} = shown_c;
   assign parse_err = err_q;
   assign cmd_drop  = drop_q;

endmodule

// File: tb/tb_calc_cmd_parser.sv
// Scoreboard bench for calc_cmd_parser: expected commands are queued as lines
// are sent and compared whenever the DUT hands a command to the consumer.
module tb_calc_cmd_parser;

   localparam int unsigned OPW   = 16;
   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic           s;
      logic [4:0]     op;
      logic [OPW-1:0] a;
      logic [OPW-1:0] b;
   } exp_t;

   logic                   clk;
   logic                   n_rst;
   logic [7:0]             rx_data;
   logic                   rx_valid;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic                   cmd_signed;
   logic [4:0]             cmd_op;
   logic [OPW-1:0]         cmd_src1;
   logic [OPW-1:0]         cmd_src2;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   parse_err;
   logic                   cmd_drop;

   exp_t sb[$];
   int   checks    = 0;
   int   errors    = 0;
   int   err_seen  = 0;
   int   drop_seen = 0;

   calc_cmd_parser #(.OPW(OPW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_signed (cmd_signed),
      .cmd_op     (cmd_op),
      .cmd_src1   (cmd_src1),
      .cmd_src2   (cmd_src2),
      .fifo_count (fifo_count),
      .parse_err  (parse_err),
      .cmd_drop   (cmd_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled 1 ns after each rising edge.
   always @(posedge clk) begin
      #1;
      if (parse_err === 1'b1) err_seen++;
      if (cmd_drop === 1'b1) drop_seen++;
   end

   // Scoreboard consumer: every handshake is compared with the oldest expectation.
   always @(negedge clk) begin : sb_check
      exp_t e;
      exp_t g;
      #1;
      if (n_rst === 1'b0 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
         checks++;
         g = {cmd_signed, cmd_op, cmd_src1, cmd_src2};
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got %h want no entry", g);
         end else begin
            e = sb.pop_front();
            if (g !== e) begin
               errors++;
               $display("FAIL pop_data: got %h want %h", g, e);
            end
         end
      end
   end

   task automatic send_str(input string s, input bit fast);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         rx_data  = s[i];
         rx_valid = 1'b1;
         if (!fast) begin
            @(negedge clk);
            rx_valid = 1'b0;
         end
      end
      if (fast) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
   endtask

   task automatic expect_cmd(input logic s, input logic [4:0] op,
                             input logic [OPW-1:0] a, input logic [OPW-1:0] b);
      exp_t e;
      e = {s, op, a, b};
      sb.push_back(e);
   endtask

   task automatic drain();
      cmd_ready = 1'b1;
      for (int i = 0; i < 4 * DEPTH && fifo_count != 0; i++) @(negedge clk);
      cmd_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
      checks++;
      if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      checks++;
      if ({parse_err, cmd_drop} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {parse_err, cmd_drop}); end
      checks++;
      if ({cmd_signed, cmd_op, cmd_src1, cmd_src2} !== '0) begin
         errors++; $display("FAIL reset_data: got %h want 0", {cmd_signed, cmd_op, cmd_src1, cmd_src2});
      end
      n_rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      send_str("+1a,2\n", 1'b0);
      expect_cmd(1'b0, 5'd0, 16'h001A, 16'h0002);
      checks++;
      if (cmd_valid !== 1'b0) begin errors++; $display("FAIL basic_latency: got valid=%b want 0 one edge after LF", cmd_valid); end
      @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b1 || fifo_count !== 3'd1) begin
         errors++; $display("FAIL basic_valid: got valid=%b count=%0d want 1/1", cmd_valid, fifo_count);
      end
      checks++;
      if ({cmd_signed, cmd_op, cmd_src1, cmd_src2} !== {1'b0, 5'd0, 16'h001A, 16'h0002}) begin
         errors++; $display("FAIL basic_head: got %h want %h", {cmd_signed, cmd_op, cmd_src1, cmd_src2},
                            {1'b0, 5'd0, 16'h001A, 16'h0002});
      end
      drain();
   endtask

   task automatic test_signed_cr();
      send_str("s-ffff,1\r\n", 1'b0);
      expect_cmd(1'b1, 5'd1, 16'hFFFF, 16'h0001);
      @(negedge clk);
      checks++;
      if ({cmd_valid, cmd_signed, cmd_op, cmd_src1} !== {1'b1, 1'b1, 5'd1, 16'hFFFF}) begin
         errors++; $display("FAIL signed_head: got %h want %h", {cmd_valid, cmd_signed, cmd_op, cmd_src1},
                            {1'b1, 1'b1, 5'd1, 16'hFFFF});
      end
      drain();
      checks++;
      if ({cmd_valid, cmd_signed, cmd_op, cmd_src1, cmd_src2} !== '0) begin
         errors++; $display("FAIL signed_after_pop: got %h want 0", {cmd_valid, cmd_signed, cmd_op, cmd_src1, cmd_src2});
      end
   endtask

   task automatic test_digit_limit();
      int e0;
      e0 = err_seen;
      send_str("*1234", 1'b0);
      send_str("5", 1'b0);
      checks++;
      if (parse_err !== 1'b1) begin errors++; $display("FAIL limit_pulse: got %b want 1 after fifth digit", parse_err); end
      send_str(",1\n", 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (err_seen - e0 !== 1 || fifo_count !== 3'd0) begin
         errors++; $display("FAIL limit_result: got errs=%0d count=%0d want 1/0", err_seen - e0, fifo_count);
      end
      send_str("&3,5\n", 1'b0);
      expect_cmd(1'b0, 5'd5, 16'h0003, 16'h0005);
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'd1 || cmd_op !== 5'd5) begin
         errors++; $display("FAIL limit_recover: got count=%0d op=%0d want 1/5", fifo_count, cmd_op);
      end
      drain();
   endtask

   task automatic test_malformed();
      int e0;
      e0 = err_seen;
      send_str("x\n", 1'b0);
      send_str("q+1,2\n", 1'b0);
      send_str("+,1\n", 1'b0);
      send_str("+1,\n", 1'b0);
      send_str("s\n", 1'b0);
      send_str(" \n\r", 1'b0);
      send_str("^ffff,0\n", 1'b0);
      expect_cmd(1'b0, 5'd7, 16'hFFFF, 16'h0000);
      repeat (2) @(negedge clk);
      checks++;
      if (err_seen - e0 !== 5) begin errors++; $display("FAIL malformed_errs: got %0d want 5", err_seen - e0); end
      checks++;
      if (fifo_count !== 3'd1) begin errors++; $display("FAIL malformed_count: got %0d want 1", fifo_count); end
      drain();
   endtask

   task automatic test_full();
      int d0;
      d0 = drop_seen;
      send_str("+1,1\n", 1'b0);  expect_cmd(1'b0, 5'd0, 16'h1, 16'h1);
      send_str("-2,2\n", 1'b0);  expect_cmd(1'b0, 5'd1, 16'h2, 16'h2);
      send_str("*3,3\n", 1'b0);  expect_cmd(1'b0, 5'd2, 16'h3, 16'h3);
      send_str("/4,4\n", 1'b0);  expect_cmd(1'b0, 5'd3, 16'h4, 16'h4);
      send_str("%5,5\n", 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (fifo_count !== 3'd4 || drop_seen - d0 !== 1) begin
         errors++; $display("FAIL full_drop: got count=%0d drops=%0d want 4/1", fifo_count, drop_seen - d0);
      end
      drain();
      checks++;
      if (fifo_count !== 3'd0) begin errors++; $display("FAIL full_drain: got %0d want 0", fifo_count); end
      d0 = drop_seen;
      send_str("<a,1\n", 1'b0);  expect_cmd(1'b0, 5'd8, 16'hA, 16'h1);
      send_str(">b,2\n", 1'b0);  expect_cmd(1'b0, 5'd9, 16'hB, 16'h2);
      send_str("|c,3\n", 1'b0);  expect_cmd(1'b0, 5'd6, 16'hC, 16'h3);
      send_str("^d,4\n", 1'b0);  expect_cmd(1'b0, 5'd7, 16'hD, 16'h4);
      send_str("&e,5\n", 1'b0);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      expect_cmd(1'b0, 5'd5, 16'hE, 16'h5);
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'd4 || drop_seen - d0 !== 0) begin
         errors++; $display("FAIL full_pop_push: got count=%0d drops=%0d want 4/0", fifo_count, drop_seen - d0);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      int e0;
      send_str("+7,7\n", 1'b0);
      send_str("+12,", 1'b0);
      e0 = err_seen;
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
      n_rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b0 || fifo_count !== 3'd0 || err_seen - e0 !== 0) begin
         errors++; $display("FAIL midreset_clear: got valid=%b count=%0d errs=%0d want 0/0/0",
                            cmd_valid, fifo_count, err_seen - e0);
      end
      send_str("|f,0\n", 1'b0);
      expect_cmd(1'b0, 5'd6, 16'h000F, 16'h0000);
      @(negedge clk);
      checks++;
      if ({cmd_valid, cmd_op, cmd_src1, cmd_src2} !== {1'b1, 5'd6, 16'h000F, 16'h0000}) begin
         errors++; $display("FAIL midreset_next: got %h want %h", {cmd_valid, cmd_op, cmd_src1, cmd_src2},
                            {1'b1, 5'd6, 16'h000F, 16'h0000});
      end
      drain();
   endtask

   task automatic test_back_to_back();
      send_str("+ffff,FFFF\n>10,3\n", 1'b1);
      expect_cmd(1'b0, 5'd0, 16'hFFFF, 16'hFFFF);
      expect_cmd(1'b0, 5'd9, 16'h0010, 16'h0003);
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_count: got %0d want 2", fifo_count); end
      drain();
      checks++;
      if (fifo_count !== 3'd0 || sb.size() != 0) begin
         errors++; $display("FAIL b2b_drain: got count=%0d pending=%0d want 0/0", fifo_count, sb.size());
      end
   endtask

   task automatic test_decimal();
      int e0;
      e0 = err_seen;
`ifdef CALC_DEC_INPUT_EN
      send_str("+#65535,#1\n", 1'b0);
      expect_cmd(1'b0, 5'd0, 16'hFFFF, 16'h0001);
      send_str("+#65536,1\n", 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (err_seen - e0 !== 1 || fifo_count !== 3'd1) begin
         errors++; $display("FAIL dec_result: got errs=%0d count=%0d want 1/1", err_seen - e0, fifo_count);
      end
`else
      send_str("+#1,1\n", 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (err_seen - e0 !== 1 || fifo_count !== 3'd0) begin
         errors++; $display("FAIL hash_illegal: got errs=%0d count=%0d want 1/0", err_seen - e0, fifo_count);
      end
`endif
      drain();
   endtask

   initial begin
      n_rst     = 1'b1;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      cmd_ready = 1'b0;
      test_reset();
      test_basic();
      test_signed_cr();
      test_digit_limit();
      test_malformed();
      test_full();
      test_reset_mid();
      test_back_to_back();
      test_decimal();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule
